vc_flit_receiver: RTL and testbench
===================================

Name: vc_flit_receiver

Overview:
- Synthesizable receiving end of the VC time-multiplexed local injection link that the node-side packet injector drives.
- One 32-bit flit link is shared by VC virtual channels. Slot ownership rotates each cycle via a free-running counter, in lock-step with the sender.
- Accepted flits are buffered in per-VC FIFOs.
- Whole packets are forwarded, one at a time and without interleaving, on a single output stream into the router's routing stage.

Parameters:
- VC, 4, number of virtual channels / link slots (2..8)
- FIFO_DEPTH, 4, flits per VC FIFO (power of 2, >=2)
- DATA_WIDTH, 32, flit width; type field is the top 2 bits

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- data_in  in  DATA_WIDTH  flit from sender, belongs to VC slot vc_slot
- valid_in  in  1  flit valid for current slot
- ready_in  out  1  this block can accept a flit in current slot
- vc_slot  out  $clog2(VC)  current slot counter value; sender mirrors it
- data_out  out  DATA_WIDTH  forwarded flit
- valid_out  out  1  data_out valid
- ready_out  in  1  downstream accepts
- vc_out  out  $clog2(VC)  VC of the forwarded flit
- error  out  1  sticky protocol error (see Optional Feature)

Behaviour:
- Flit type [31:30]: 2'b01 head, 2'b10 body, 2'b11 tail, 2'b00 invalid. Head fields: [29:16] message id, [15:12]/[11:8] source x/y, [7:4]/[3:0] destination x/y.
- Reset (rst=0) forces: vc_slot=0, all FIFOs empty, valid_out=0, data_out=0, vc_out=0, error=0, output FSM in IDLE, rr pointer=0.
- Reset is asynchronous. Flits in flight are discarded, and no partial packet survives reset.
- Slot counter: vc_slot increments every cycle out of reset and wraps from VC-1 to 0.
- Input side:
  - ready_in = !full[vc_slot], combinational.
  - A transfer happens when valid_in & ready_in; data_in is written to FIFO[vc_slot] at that clock edge.
  - Invalid-type flits (2'b00) are dropped while ready_in stays high; they raise error when the feature is enabled.
- FIFO:
  - A write to a full FIFO cannot occur because ready_in gates it.
  - Simultaneous read and write on the same VC are both honoured; occupancy stays unchanged.
- Output FSM:
  - IDLE: round-robin scan starting at rr pointer. Pick the first VC whose FIFO is non-empty and whose front flit is a head. Latch it as cur_vc and go to SEND.
  - IDLE, non-head front flit: a VC whose front is not a head is popped and discarded (error when the feature is enabled).
  - SEND: valid_out = !empty[cur_vc]; data_out = FIFO[cur_vc] front; vc_out = cur_vc.
  - SEND pop: pop happens on valid_out & ready_out.
  - SEND exit: a popped tail sets rr pointer = cur_vc+1 (mod VC) and returns to IDLE.
  - SEND, FIFO empty mid-packet: valid_out=0 and the FSM stays in SEND. No other VC may interleave.
  - data_out/vc_out must hold stable while valid_out & !ready_out.
- Latency:
  - A head written at edge t can appear on valid_out no earlier than edge t+2 (one cycle FIFO, one cycle IDLE selection).
  - Body flits stream at 1 flit/cycle when the FIFO is non-empty and ready_out=1.
- A single-flit packet (head with type 2'b11 is not allowed) always consists of at least head + tail.

Optional Feature:
- Macro: VC_RX_PROTOCOL_CHECK_EN.
- When defined, each VC runs a 2-state input tracker, OUT / IN_PKT, on writes:
  - head in IN_PKT -> error.
  - body or tail in OUT -> error.
  - type 2'b00 -> error.
  - head moves to IN_PKT; tail moves to OUT.
- error is sticky until reset. Flits are still stored or dropped as above.
- When undefined: the trackers are absent, error is tied to 0, and behaviour is otherwise identical.

Decomposition:
- Shared package/header vc_noc_defs:
  - flit type constants FLIT_HEAD/BODY/TAIL/INV
  - header field bit positions
  - function computing destination node index = y*DIM+x
- One sub-module, vc_flit_fifo: synchronous FIFO with full/empty, registered pointers and async active-low reset. Instantiated VC times.

Test Plan:
- Reset then idle: after rst rises, vc_slot counts 0,1,2,3,0; ready_in=1; valid_out=0; error=0.
- Single VC packet:
  - Stimulus: on slot 2, send head 0x4000_0021, body 0x8000_0000, tail 0xC000_0021, with ready_out=1.
  - Response: data_out emits the 3 flits in order with vc_out=2; first valid_out no earlier than 2 cycles after the head write.
- Interleaved input, packet-atomic output:
  - Stimulus: VC0 and VC1 each send a 4-flit packet, alternating slots.
  - Response: output shows all 4 VC0 flits, then all 4 VC1 flits, never mixed; the next round-robin choice starts at VC1+1.
- Backpressure/full:
  - Stimulus: ready_out=0, send 5 flits on VC3 with FIFO_DEPTH=4.
  - Response: ready_in drops in slot 3 after the 4th write; the 5th is held by the sender; data_out is stable. After ready_out=1, all 5 arrive.
- Protocol error (VC_RX_PROTOCOL_CHECK_EN):
  - Stimulus: body 0x8000_0000 on idle VC1.
  - Response: error=1 and stays 1; the flit is discarded at output. Without the macro, error stays 0.
- Reset mid-packet:
  - Stimulus: assert rst low during the body of a VC0 packet, release, send a fresh packet.
  - Response: outputs are zero immediately (async); the old flits never appear; the new packet is forwarded intact.

Source files
------------

// File: rtl/vc_noc_defs.sv
// Shared NoC definitions: flit type encodings, head-flit field positions,
// receiver FSM states and mesh node indexing.
package vc_noc_defs;

    localparam logic [1:0] FLIT_INV  = 2'b00;
    localparam logic [1:0] FLIT_HEAD = 2'b01;
    localparam logic [1:0] FLIT_BODY = 2'b10;
    localparam logic [1:0] FLIT_TAIL = 2'b11;

    localparam int unsigned HDR_MSG_ID_MSB = 29;
    localparam int unsigned HDR_MSG_ID_LSB = 16;
    localparam int unsigned HDR_SRC_X_MSB  = 15;
    localparam int unsigned HDR_SRC_X_LSB  = 12;
    localparam int unsigned HDR_SRC_Y_MSB  = 11;
    localparam int unsigned HDR_SRC_Y_LSB  = 8;
    localparam int unsigned HDR_DST_X_MSB  = 7;
    localparam int unsigned HDR_DST_X_LSB  = 4;
    localparam int unsigned HDR_DST_Y_MSB  = 3;
    localparam int unsigned HDR_DST_Y_LSB  = 0;

    typedef enum logic {
        StIdle,
        StSend
    } rx_state_e;

    function automatic int unsigned dest_node_idx(input logic [3:0] x, input logic [3:0] y,
                                                  input int unsigned dim);
        return 32'(y) * dim + 32'(x);
    endfunction

endpackage

// File: rtl/vc_flit_fifo.sv
// Per-VC synchronous FIFO with registered wrap-bit pointers and a
// combinational front-of-queue read port.
module vc_flit_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_wr, do_rd;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: empty pointers hide stale contents.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/vc_flit_receiver.sv
// Receiving end of the slot-multiplexed VC injection link: per-VC FIFOs feeding a
// packet-atomic round-robin output. Define VC_RX_PROTOCOL_CHECK_EN for protocol trackers.
module vc_flit_receiver
    import vc_noc_defs::*;
#(
    parameter int unsigned VC         = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  ready_in,
    output logic [$clog2(VC)-1:0] vc_slot,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    input  logic                  ready_out,
    output logic [$clog2(VC)-1:0] vc_out,
    output logic                  error
);

    localparam int unsigned SW = $clog2(VC);

    logic [SW-1:0]         slot_q, slot_d;
    logic [SW-1:0]         cur_vc_q, cur_vc_d;
    logic [SW-1:0]         rr_q, rr_d;
    logic [SW-1:0]         sel_vc, scan_vc;
    rx_state_e             state_q, state_d;
    logic [VC-1:0]         wr_en, rd_en, full, empty, front_head, drop;
    logic [DATA_WIDTH-1:0] front [VC];
    logic [1:0]            in_type, out_type;
    logic                  accept, sel_found;

    assign vc_slot  = slot_q;
    assign ready_in = !full[slot_q];
    assign accept   = valid_in && ready_in;
    assign in_type  = data_in[DATA_WIDTH-1 -: 2];
    assign slot_d   = (slot_q == SW'(VC - 1)) ? '0 : slot_q + 1'b1;

    always_comb begin
        wr_en = '0;
        if (accept && (in_type != FLIT_INV)) wr_en[slot_q] = 1'b1;
    end

    for (genvar v = 0; v < VC; v++) begin : g_vc
        vc_flit_fifo #(
            .DEPTH(FIFO_DEPTH),
            .WIDTH(DATA_WIDTH)
        ) u_fifo (
            .clk    (clk),
            .rst    (rst),
            .wr_en  (wr_en[v]),
            .wr_data(data_in),
            .rd_en  (rd_en[v]),
            .rd_data(front[v]),
            .full   (full[v]),
            .empty  (empty[v])
        );
        assign front_head[v] = !empty[v] && (front[v][DATA_WIDTH-1 -: 2] == FLIT_HEAD);
        assign drop[v]       = !empty[v] && (front[v][DATA_WIDTH-1 -: 2] != FLIT_HEAD);
    end

    // First head-fronted VC at or after the round-robin pointer.
    always_comb begin
        sel_found = 1'b0;
        sel_vc    = '0;
        scan_vc   = '0;
        for (int unsigned i = 0; i < VC; i++) begin
            scan_vc = SW'((32'(rr_q) + i) % VC);
            if (!sel_found && front_head[scan_vc]) begin
                sel_found = 1'b1;
                sel_vc    = scan_vc;
            end
        end
    end

    assign out_type = front[cur_vc_q][DATA_WIDTH-1 -: 2];

    always_comb begin
        state_d   = state_q;
        cur_vc_d  = cur_vc_q;
        rr_d      = rr_q;
        rd_en     = '0;
        valid_out = 1'b0;
        data_out  = '0;
        vc_out    = '0;
        unique case (state_q)
            StIdle: begin
                // Stray non-head fronts are flushed so they cannot block selection.
                rd_en = drop;
                if (sel_found) begin
                    cur_vc_d = sel_vc;
                    state_d  = StSend;
                end
            end
            StSend: begin
                valid_out = !empty[cur_vc_q];
                vc_out    = cur_vc_q;
                if (valid_out) data_out = front[cur_vc_q];
                if (valid_out && ready_out) begin
                    rd_en[cur_vc_q] = 1'b1;
                    if (out_type == FLIT_TAIL) begin
                        rr_d    = (cur_vc_q == SW'(VC - 1)) ? '0 : cur_vc_q + 1'b1;
                        state_d = StIdle;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_q   <= '0;
            state_q  <= StIdle;
            cur_vc_q <= '0;
            rr_q     <= '0;
        end else begin
            slot_q   <= slot_d;
            state_q  <= state_d;
            cur_vc_q <= cur_vc_d;
            rr_q     <= rr_d;
        end
    end

`ifdef VC_RX_PROTOCOL_CHECK_EN
    logic [VC-1:0] in_pkt_q, in_pkt_d;
    logic          err_q, err_d;

    always_comb begin
        in_pkt_d = in_pkt_q;
        err_d    = err_q;
        if (accept) begin
            unique case (in_type)
                FLIT_HEAD: begin
                    if (in_pkt_q[slot_q]) err_d = 1'b1;
                    in_pkt_d[slot_q] = 1'b1;
                end
                FLIT_BODY: begin
                    if (!in_pkt_q[slot_q]) err_d = 1'b1;
                end
                FLIT_TAIL: begin
                    if (!in_pkt_q[slot_q]) err_d = 1'b1;
                    in_pkt_d[slot_q] = 1'b0;
                end
                default: err_d = 1'b1;
            endcase
        end
        if ((state_q == StIdle) && (|drop)) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_pkt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            in_pkt_q <= in_pkt_d;
            err_q    <= err_d;
        end
    end

    assign error = err_q;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_vc_flit_receiver.sv
// Self-checking bench for vc_flit_receiver: directed scenarios plus randomized
// packet traffic scored per VC against a packet-level reference model.
module tb_vc_flit_receiver;

    localparam int unsigned VC    = 4;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = 32;
`ifdef VC_RX_PROTOCOL_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic          clk, rst, valid_in, ready_in, valid_out, ready_out, error;
    logic [DW-1:0] data_in, data_out;
    logic [1:0]    vc_slot, vc_out;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q [VC][$];
    logic [31:0] src_q [VC][$];
    logic [1:0]  log_vc [$];
    logic [31:0] log_data [$];
    logic        m_in_pkt;
    logic [1:0]  m_vc;
    int          m_v;
    bit          rand_rdy = 1'b0;

    vc_flit_receiver #(
        .VC        (VC),
        .FIFO_DEPTH(DEPTH),
        .DATA_WIDTH(DW)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .valid_in (valid_in),
        .ready_in (ready_in),
        .vc_slot  (vc_slot),
        .data_out (data_out),
        .valid_out(valid_out),
        .ready_out(ready_out),
        .vc_out   (vc_out),
        .error    (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int total_exp();
        int t = 0;
        for (int v = 0; v < VC; v++) t += exp_q[v].size();
        return t;
    endfunction

    // Scoreboard: every forwarded flit must be the next expected flit of its VC and
    // packets must leave head-first and unbroken.
    always @(negedge clk) begin
        if (!rst) begin
            m_in_pkt = 1'b0;
        end else if (valid_out && ready_out) begin
            m_v = int'(vc_out);
            log_vc.push_back(vc_out);
            log_data.push_back(data_out);
            if (m_in_pkt) check_eq("mon_no_interleave", vc_out, m_vc);
            else          check_eq("mon_starts_with_head", data_out[31:30], 2'b01);
            check_eq("mon_flit_expected", exp_q[m_v].size() != 0, 1);
            if (exp_q[m_v].size() != 0) check_eq("mon_flit_data", data_out, exp_q[m_v].pop_front());
            m_in_pkt = (data_out[31:30] != 2'b11);
            m_vc     = vc_out;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) ready_out = ($urandom_range(0, 3) != 0);
        end
    end

    // Called at posedge+1; waits for the VC's slot with space, then drives one cycle.
    task automatic send_flit(input int vc, input logic [31:0] d, input bit store);
        int n = 0;
        while (!((int'(vc_slot) == vc) && ready_in) && (n < 200)) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("send_slot_wait", n < 200, 1);
        if (n < 200) begin
            valid_in = 1'b1;
            data_in  = d;
            if (store) exp_q[vc].push_back(d);
            @(posedge clk);
            #1;
            valid_in = 1'b0;
        end
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (((total_exp() != 0) || m_in_pkt) && (n < 3000)) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq(tag, n < 3000, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_log(input int i, input logic [1:0] v, input logic [31:0] d);
        check_eq("log_vc", (i < log_vc.size()) ? log_vc[i] : 2'bxx, v);
        check_eq("log_data", (i < log_data.size()) ? log_data[i] : 32'hxxxx_xxxx, d);
    endtask

    logic [31:0] p0 [4] = '{32'h4000_0100, 32'h8000_0001, 32'h8000_0002, 32'hC000_0003};
    logic [31:0] p1 [4] = '{32'h4000_0200, 32'h8000_0011, 32'h8000_0012, 32'hC000_0013};
    logic [31:0] bp [5] = '{32'h4000_0600, 32'h8000_0601, 32'h8000_0602, 32'h8000_0603,
                            32'hC000_0604};
    logic [31:0] d;
    int          pv, len, pending, n, s;

    initial begin
        rst       = 1'b0;
        valid_in  = 1'b0;
        data_in   = '0;
        ready_out = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values, then free-running slot counter.
        check_eq("rst_vc_slot", vc_slot, 0);
        check_eq("rst_ready_in", ready_in, 1);
        check_eq("rst_valid_out", valid_out, 0);
        check_eq("rst_data_out", data_out, 0);
        check_eq("rst_vc_out", vc_out, 0);
        check_eq("rst_error", error, 0);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_eq("slot_count", vc_slot, i % VC);
            check_eq("idle_ready_in", ready_in, 1);
            check_eq("idle_valid_out", valid_out, 0);
            @(negedge clk);
        end
        check_eq("idle_error", error, 0);
        @(posedge clk);
        #1;

        // Single packet on VC2 with latency bound.
        ready_out = 1'b1;
        log_vc.delete();
        log_data.delete();
        send_flit(2, 32'h4000_0021, 1);
        @(negedge clk);
        check_eq("lat_not_before_t2", valid_out, 0);
        @(negedge clk);
        check_eq("lat_valid_by_t2", valid_out, 1);
        @(posedge clk);
        #1;
        send_flit(2, 32'h8000_0000, 1);
        send_flit(2, 32'hC000_0021, 1);
        drain("single_drain");
        check_eq("single_count", log_data.size(), 3);
        check_log(0, 2, 32'h4000_0021);
        check_log(1, 2, 32'h8000_0000);
        check_log(2, 2, 32'hC000_0021);

        // Interleaved input on VC0/VC1, packet-atomic output.
        log_vc.delete();
        log_data.delete();
        for (int k = 0; k < 4; k++) begin
            send_flit(0, p0[k], 1);
            send_flit(1, p1[k], 1);
        end
        drain("inter_drain");
        check_eq("inter_count", log_data.size(), 8);
        for (int k = 0; k < 4; k++) begin
            check_log(k, 0, p0[k]);
            check_log(k + 4, 1, p1[k]);
        end

        // Round-robin resumes after VC1: VC3 must beat VC0; output held while stalled.
        ready_out = 1'b0;
        log_vc.delete();
        log_data.delete();
        send_flit(1, 32'h4000_0300, 1);
        send_flit(0, 32'h4000_0400, 1);
        send_flit(3, 32'h4000_0500, 1);
        send_flit(0, 32'hC000_0400, 1);
        send_flit(3, 32'hC000_0500, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("stall_valid", valid_out, 1);
            check_eq("stall_vc", vc_out, 1);
            check_eq("stall_data", data_out, 32'h4000_0300);
        end
        @(posedge clk);
        #1;
        send_flit(1, 32'hC000_0300, 1);
        ready_out = 1'b1;
        drain("rr_drain");
        check_eq("rr_count", log_data.size(), 6);
        check_log(0, 1, 32'h4000_0300);
        check_log(1, 1, 32'hC000_0300);
        check_log(2, 3, 32'h4000_0500);
        check_log(3, 3, 32'hC000_0500);
        check_log(4, 0, 32'h4000_0400);
        check_log(5, 0, 32'hC000_0400);

        // Backpressure: VC3 FIFO fills, fifth flit waits for space.
        ready_out = 1'b0;
        log_vc.delete();
        log_data.delete();
        for (int k = 0; k < 4; k++) send_flit(3, bp[k], 1);
        n = 0;
        while ((vc_slot != 2'd3) && (n < 10)) begin
            if (vc_slot == 2'd0) check_eq("full_other_slot_ready", ready_in, 1);
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("full_ready_in", ready_in, 0);
        check_eq("full_valid_out", valid_out, 1);
        check_eq("full_data_out", data_out, bp[0]);
        check_eq("full_vc_out", vc_out, 3);
        ready_out = 1'b1;
        send_flit(3, bp[4], 1);
        drain("full_drain");
        check_eq("full_count", log_data.size(), 5);
        for (int k = 0; k < 5; k++) check_log(k, 3, bp[k]);

        // Stray body on idle VC1.
        log_vc.delete();
        log_data.delete();
        send_flit(1, 32'h8000_0000, 0);
        repeat (4) @(posedge clk);
        #1;
        check_eq("proto_error", error, EXP_ERR);
        repeat (10) @(posedge clk);
        #1;
        check_eq("proto_error_sticky", error, EXP_ERR);
        check_eq("proto_discarded", log_data.size(), 0);

        // Asynchronous reset in the middle of a VC0 packet.
        ready_out = 1'b0;
        send_flit(0, 32'h4000_0700, 1);
        send_flit(0, 32'h8000_0701, 1);
        check_eq("rst_pre_valid", valid_out, 1);
        #2;
        rst = 1'b0;
        for (int v = 0; v < VC; v++) exp_q[v].delete();
        #1;
        check_eq("arst_valid_out", valid_out, 0);
        check_eq("arst_data_out", data_out, 0);
        check_eq("arst_vc_out", vc_out, 0);
        check_eq("arst_error", error, 0);
        check_eq("arst_vc_slot", vc_slot, 0);
        check_eq("arst_ready_in", ready_in, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        ready_out = 1'b1;
        log_vc.delete();
        log_data.delete();
        send_flit(0, 32'h4000_0800, 1);
        send_flit(0, 32'h8000_0801, 1);
        send_flit(0, 32'hC000_0802, 1);
        drain("arst_drain");
        check_eq("arst_count", log_data.size(), 3);
        check_log(0, 0, 32'h4000_0800);
        check_log(1, 0, 32'h8000_0801);
        check_log(2, 0, 32'hC000_0802);

        // Randomized well-formed traffic with random backpressure.
        pending = 0;
        for (int p = 0; p < 30; p++) begin
            pv  = int'($urandom_range(0, VC - 1));
            len = int'($urandom_range(2, 5));
            src_q[pv].push_back({2'b01, 14'(p), 16'($urandom)});
            for (int k = 1; k < len - 1; k++) src_q[pv].push_back({2'b10, 30'($urandom)});
            src_q[pv].push_back({2'b11, 30'($urandom)});
            pending += len;
        end
        rand_rdy = 1'b1;
        n = 0;
        while ((pending != 0) && (n < 20000)) begin
            s = int'(vc_slot);
            if ((src_q[s].size() != 0) && ready_in && ($urandom_range(0, 3) != 0)) begin
                d        = src_q[s].pop_front();
                valid_in = 1'b1;
                data_in  = d;
                exp_q[s].push_back(d);
                pending--;
                @(posedge clk);
                #1;
                valid_in = 1'b0;
            end else begin
                @(posedge clk);
                #1;
            end
            n++;
        end
        check_eq("rand_all_sent", pending, 0);
        #1;
        rand_rdy  = 1'b0;
        ready_out = 1'b1;
        drain("rand_drain");
        check_eq("rand_no_error", error, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
